// File: rtl/lcb_sim_if.sv
// RS-485 transceiver pins plus the received-byte output of the LCB link simulator.
`timescale 1ns/1ps
interface lcb_sim_if;
  logic       UART_RX;
  logic       UART_TX;
  logic       UART_dTX;
  logic       UART_dRX;
  logic [7:0] dataFromLCB;
  logic       ValRX;

  // master: the link simulator itself
  modport master (
    input  UART_RX,
    output UART_TX, UART_dTX, UART_dRX, dataFromLCB, ValRX
  );

  // slave: the board / LCB side of the wire
  modport slave (
    output UART_RX,
    input  UART_TX, UART_dTX, UART_dRX, dataFromLCB, ValRX
  );
endinterface

// File: rtl/lcb_sim.sv
// LCB link simulator: periodic 2-byte request on a half-duplex RS-485 UART,
// then listens and strobes out every correctly framed response byte.
`timescale 1ns/1ps
module lcb_sim #(
  parameter int         CLKS_PER_BIT = 34,
  parameter int         PERIOD       = 16000,
  parameter logic [7:0] LCB_ADDR     = 8'h01
) (
  input  logic      clk80MHz,
  input  logic      rst_n,
  lcb_sim_if.master bus
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [PW-1:0] PER_LAST  = PW'(PERIOD - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_GUARD_PRE, TX_SEND, TX_GUARD_POST} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // ---------------- period counter ----------------
  logic [PW-1:0] per_cnt_q;
  logic          per_wrap;

  assign per_wrap = (per_cnt_q == PER_LAST);

  // free-running request period; a wrap launches a request if TX is idle
  always_ff @(posedge clk80MHz or negedge rst_n) begin
    if (!rst_n)        per_cnt_q <= '0;
    else if (per_wrap) per_cnt_q <= '0;
    else               per_cnt_q <= per_cnt_q + 1'b1;
  end

  // ---------------- TX path ----------------
  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q,   tx_cnt_d;
  logic [4:0]    tx_bit_q,   tx_bit_d;
  logic [19:0]   tx_sh_q,    tx_sh_d;
  logic [7:0]    req_cnt_q,  req_cnt_d;
  logic          tx_q,       tx_d;
  logic          dtx_q,      dtx_d;

  // TX state and registered line/enable outputs
  always_ff @(posedge clk80MHz or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '1;
      req_cnt_q  <= '0;
      tx_q       <= 1'b1;
      dtx_q      <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      req_cnt_q  <= req_cnt_d;
      tx_q       <= tx_d;
      dtx_q      <= dtx_d;
    end
  end

  // guard / two back-to-back frames / guard; outputs derived from next state
  // so the pins change on the same edge as the state
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    req_cnt_d  = req_cnt_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (per_wrap) begin
          tx_state_d = TX_GUARD_PRE;
          tx_cnt_d   = '0;
        end
      end
      TX_GUARD_PRE: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_state_d = TX_SEND;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          // {stop, byte1, start, stop, byte0, start}, shifted out LSB first
          tx_sh_d    = {1'b1, req_cnt_q, 1'b0, 1'b1, LCB_ADDR, 1'b0};
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_SEND: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          tx_sh_d  = {1'b1, tx_sh_q[19:1]};
          if (tx_bit_q == 5'd19) tx_state_d = TX_GUARD_POST;
          else                   tx_bit_d   = tx_bit_q + 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_GUARD_POST: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_state_d = TX_IDLE;
          tx_cnt_d   = '0;
          req_cnt_d  = req_cnt_q + 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    tx_d  = (tx_state_d == TX_SEND) ? tx_sh_d[0] : 1'b1;
    dtx_d = (tx_state_d != TX_IDLE);
  end

  // ---------------- RX path ----------------
  logic rx_s1_q, rx_s2_q, rx_prev_q;
  logic rx_fall;

  assign rx_fall = rx_prev_q & ~rx_s2_q;

  // 2-flop synchronizer plus one delayed copy for edge detection
  always_ff @(posedge clk80MHz or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= bus.UART_RX;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q,   rx_cnt_d;
  logic [2:0]    rx_bit_q,   rx_bit_d;
  logic [7:0]    rx_sh_q,    rx_sh_d;
  logic [7:0]    data_q,     data_d;
  logic          val_q,      val_d;

  // RX state and received-byte outputs
  always_ff @(posedge clk80MHz or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      data_q     <= '0;
      val_q      <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      data_q     <= data_d;
      val_q      <= val_d;
    end
  end

  // mid-bit sampling receiver; held in IDLE while our own driver is on
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    data_d     = data_q;
    val_d      = 1'b0;
    if (dtx_q) begin
      rx_state_d = RX_IDLE;
      rx_cnt_d   = '0;
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_state_d = RX_START;
            rx_cnt_d   = '0;
          end
        end
        RX_START: begin
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_d = '0;
            rx_bit_d = '0;
            // high at mid start bit means the edge was a glitch
            rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_d = '0;
            rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            else                  rx_bit_d   = rx_bit_q + 1'b1;
          end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_d   = '0;
            rx_state_d = RX_IDLE;
            // a low stop bit is a framing error: drop the byte silently
            if (rx_s2_q) begin
              data_d = rx_sh_q;
              val_d  = 1'b1;
            end
          end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
          end
        end
        default: rx_state_d = RX_IDLE;
      endcase
    end
  end

  assign bus.UART_TX     = tx_q;
  assign bus.UART_dTX    = dtx_q;
  assign bus.UART_dRX    = dtx_q;
  assign bus.dataFromLCB = data_q;
  assign bus.ValRX       = val_q;

endmodule

// File: tb/tb_lcb_sim.sv
// Bench for lcb_sim: a default-parameter instance for timing/response checks
// and a fast instance (short bit time and period) for the long wrap run.
`timescale 1ns/1ps
module tb_lcb_sim;
  logic clk80MHz = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   r1_g = 0;

  lcb_sim_if if_m ();
  lcb_sim_if if_f ();

  lcb_sim u_dut (
    .clk80MHz (clk80MHz),
    .rst_n    (rst_n),
    .bus      (if_m)
  );

  lcb_sim #(.CLKS_PER_BIT(4), .PERIOD(160), .LCB_ADDR(8'hA5)) u_fast (
    .clk80MHz (clk80MHz),
    .rst_n    (rst_n),
    .bus      (if_f)
  );

  always #6.25 clk80MHz = ~clk80MHz;
  always @(posedge clk80MHz) cyc <= cyc + 1;

  logic [7:0] got_m[$], got_f[$], exp_m[$], exp_f[$];

  // every clock with ValRX high is one received byte
  always @(negedge clk80MHz) begin
    if (if_m.ValRX) got_m.push_back(if_m.dataFromLCB);
    if (if_f.ValRX) got_f.push_back(if_f.dataFromLCB);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_tx(input bit sel);
    return sel ? if_f.UART_TX : if_m.UART_TX;
  endfunction

  function automatic logic get_drx(input bit sel);
    return sel ? if_f.UART_dRX : if_m.UART_dRX;
  endfunction

  task automatic set_rx(input bit sel, input logic v);
    if (sel) if_f.UART_RX = v;
    else     if_m.UART_RX = v;
  endtask

  task automatic uart_send(input bit sel, input logic [7:0] d, input real bit_ns,
                           input logic stop, input int idle_bits);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    set_rx(sel, 1'b1);
    #(bit_ns * idle_bits);
    for (int i = 0; i < 10; i++) begin
      set_rx(sel, fr[i]);
      #(bit_ns);
    end
    set_rx(sel, 1'b1);
  endtask

  // counts clocks until dRX is high (bounded)
  task automatic wait_rise(input bit sel, input int budget, output int n);
    n = 0;
    while (!get_drx(sel) && n < budget) begin
      @(posedge clk80MHz); #1;
      n++;
    end
  endtask

  // called just after dRX rose; decodes both request bytes at bit centres
  task automatic decode(input bit sel, input int cpb, output logic [7:0] b0,
                        output logic [7:0] b1, output logic frm_ok,
                        output int pre, output int post);
    logic [19:0] bits;
    pre = 0;
    while (get_tx(sel) && pre < 4 * cpb) begin
      @(posedge clk80MHz); #1;
      pre++;
    end
    for (int i = 0; i < 20; i++) begin
      repeat (cpb / 2) @(posedge clk80MHz);
      #1;
      bits[i] = get_tx(sel);
      repeat (cpb - cpb / 2) @(posedge clk80MHz);
      #1;
    end
    b0     = bits[8:1];
    b1     = bits[18:11];
    frm_ok = !bits[0] && bits[9] && !bits[10] && bits[19];
    post = 0;
    while (get_drx(sel) && post < 4 * cpb) begin
      @(posedge clk80MHz); #1;
      post++;
    end
  endtask

  task automatic check_queue(input string tag, input bit sel);
    int ng, ne;
    ng = sel ? got_f.size() : got_m.size();
    ne = sel ? exp_f.size() : exp_m.size();
    chk({tag, "_count"}, ng, ne);
    for (int i = 0; i < ng && i < ne; i++)
      chk({tag, "_byte"}, sel ? got_f[i] : got_m[i], sel ? exp_f[i] : exp_m[i]);
  endtask

  task automatic main_seq();
    int n, pre, post;
    logic [7:0] b0, b1, d;
    logic fok;
    logic [7:0] fixed [8];
    real bt;
    fixed = '{8'd42, 8'd33, 8'd80, 8'd186, 8'd42, 8'd32, 8'd80, 8'd78};

    wait_rise(1'b0, 20000, n);
    chk("first_rise_clks", n, 16000);
    r1_g = cyc;
    decode(1'b0, 34, b0, b1, fok, pre, post);
    chk("req1_b0", b0, 8'h01);
    chk("req1_b1", b1, 8'h00);
    chk("req1_frame", fok, 1'b1);
    chk("req1_guard_pre", pre, 34);
    chk("req1_guard_post", post, 34);

    // response window
    for (int i = 0; i < 8; i++) begin
      uart_send(1'b0, fixed[i], 420.0, 1'b1, 10);
      exp_m.push_back(fixed[i]);
    end
    uart_send(1'b0, 8'hE7, 420.0, 1'b0, 10);      // framing error, dropped
    uart_send(1'b0, 8'h55, 420.0, 1'b1, 10);
    exp_m.push_back(8'h55);
    #(420.0 * 3);
    if_m.UART_RX = 1'b0; #62.5; if_m.UART_RX = 1'b1;   // 5-clock glitch
    #(420.0 * 3);
    uart_send(1'b0, 8'hA3, 412.5, 1'b1, 10);      // 33 clocks/bit
    exp_m.push_back(8'hA3);
    uart_send(1'b0, 8'h3C, 437.5, 1'b1, 10);      // 35 clocks/bit
    exp_m.push_back(8'h3C);
    for (int i = 0; i < 4; i++) begin
      d  = 8'($urandom);
      bt = real'($urandom_range(413, 437));
      uart_send(1'b0, d, bt, 1'b1, 10);
      exp_m.push_back(d);
    end
    #(420.0 * 30);
    check_queue("rx", 1'b0);

    // second request, with bytes arriving across and inside the blanking window
    fork
      begin
        while (cyc < r1_g + 15850) @(posedge clk80MHz);
        uart_send(1'b0, 8'hC3, 420.0, 1'b1, 0);
        uart_send(1'b0, 8'h96, 420.0, 1'b1, 0);
      end
      begin
        wait_rise(1'b0, 16500, n);
        chk("req2_period", cyc - r1_g, 16000);
        decode(1'b0, 34, b0, b1, fok, pre, post);
        chk("req2_b0", b0, 8'h01);
        chk("req2_b1", b1, 8'h01);
        chk("req2_frame", fok, 1'b1);
        chk("req2_guard", pre * 256 + post, 34 * 256 + 34);
      end
    join
    repeat (100) @(posedge clk80MHz);
    #1;
    chk("blank_no_strobe", got_m.size(), exp_m.size());
  endtask

  task automatic fast_seq();
    int n, pre, post;
    logic [7:0] b0, b1, d;
    logic fok;
    for (int k = 0; k < 260; k++) begin
      wait_rise(1'b1, 400, n);
      chk("f_rise_seen", get_drx(1'b1), 1'b1);
      if (k == 0) chk("f_first_rise_clks", n, 160);
      decode(1'b1, 4, b0, b1, fok, pre, post);
      chk("f_addr", b0, 8'hA5);
      chk("f_req_cnt", b1, k % 256);
      chk("f_frame", fok, 1'b1);
      chk("f_guard", pre * 256 + post, 4 * 256 + 4);
      if ($urandom_range(0, 3) != 0) begin
        d = 8'($urandom);
        uart_send(1'b1, d, 50.0, 1'b1, 1);
        exp_f.push_back(d);
      end
    end
    repeat (100) @(posedge clk80MHz);
    #1;
    check_queue("f_rx", 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    if_m.UART_RX = 1'b1;
    if_f.UART_RX = 1'b1;
    #30;
    chk("rst_tx", if_m.UART_TX, 1'b1);
    chk("rst_dtx", if_m.UART_dTX, 1'b0);
    chk("rst_drx", if_m.UART_dRX, 1'b0);
    chk("rst_data", if_m.dataFromLCB, 8'h00);
    chk("rst_val", if_m.ValRX, 1'b0);
    @(negedge clk80MHz);
    rst_n = 1'b1;

    fork
      main_seq();
      fast_seq();
    join

    // asynchronous reset in the middle of the third request
    while (cyc < r1_g + 32100) @(posedge clk80MHz);
    #3;
    chk("req3_active", if_m.UART_dTX, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_tx", if_m.UART_TX, 1'b1);
    chk("arst_dtx", if_m.UART_dTX, 1'b0);
    chk("arst_drx", if_m.UART_dRX, 1'b0);
    chk("arst_data", if_m.dataFromLCB, 8'h00);
    chk("arst_val", if_m.ValRX, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
